// File: rtl/pwm_timer.sv
// pwm_timer: Wishbone-controlled 16-bit PWM / periodic timer with prescaler,
// external count source and optional streamed duty cycle.
module pwm_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_adr,
    input  logic [15:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [15:0] o_wb_data,
    input  logic        i_extclk,
    input  logic [15:0] i_DC,
    input  logic        i_DC_valid,
    output logic        o_pwm
);
    logic [15:0] ctrl_q, ctrl_d, div_q, div_d, per_q, per_d, dc_q, dc_d;
    logic [15:0] ext_dc_q, ext_dc_d, pre_q, pre_d, cnt_q, cnt_d, rdata_q, rdata_d;
    logic [15:0] div_eff, duty, rd_mux;
    logic [2:0]  sync_q, sync_d;
    logic        ack_q, ack_d, pwm_q, pwm_d;
    logic        req, wr, src, run, tick, wrap;

    always_comb begin
        req      = i_wb_cyc & i_wb_stb & ~ack_q;
        wr       = req & i_wb_we;
        ack_d    = req;
        // sync_q[1:0] synchronise i_extclk; sync_q[2] gives the rising-edge detect
        sync_d   = {sync_q[1:0], i_extclk};
        src      = ctrl_q[0] ? (sync_q[1] & ~sync_q[2]) : 1'b1;
        div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
        run      = ctrl_q[2] & ~ctrl_q[7];
        tick     = run & src & (pre_q >= div_eff - 16'd1);
        pre_d    = ctrl_q[7] ? 16'd0 : (run & src) ? (tick ? 16'd0 : pre_q + 16'd1) : pre_q;
        wrap     = tick & (per_q != 16'd0) & (cnt_q >= per_q - 16'd1);
        cnt_d    = (ctrl_q[7] | (per_q == 16'd0)) ? 16'd0 : tick ? (wrap ? 16'd0 : cnt_q + 16'd1) : cnt_q;
        duty     = ctrl_q[6] ? ext_dc_q : dc_q;
        pwm_d    = ctrl_q[1] ? (ctrl_q[4] & ctrl_q[2] & (cnt_q < duty) & (per_q != 16'd0))
                             : (ctrl_q[4] & wrap);
        ctrl_d   = (wr && i_wb_adr == 4'h0) ? i_wb_data : ctrl_q;
        ctrl_d[5] = ctrl_d[5] | (wrap & ~ctrl_q[1]);
        div_d    = (wr && i_wb_adr == 4'h1) ? i_wb_data : div_q;
        per_d    = (wr && i_wb_adr == 4'h2) ? i_wb_data : per_q;
        dc_d     = (wr && i_wb_adr == 4'h3) ? i_wb_data : dc_q;
        ext_dc_d = i_DC_valid ? i_DC : ext_dc_q;
        rd_mux   = (i_wb_adr == 4'h0) ? ctrl_q :
                   (i_wb_adr == 4'h1) ? div_q  :
                   (i_wb_adr == 4'h2) ? per_q  :
                   (i_wb_adr == 4'h3) ? dc_q   : 16'd0;
        rdata_d  = (req & ~i_wb_we) ? rd_mux : rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q   <= 16'd0;
            div_q    <= 16'd0;
            per_q    <= 16'd0;
            dc_q     <= 16'd0;
            ext_dc_q <= 16'd0;
            pre_q    <= 16'd0;
            cnt_q    <= 16'd0;
            rdata_q  <= 16'd0;
            sync_q   <= 3'd0;
            ack_q    <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            per_q    <= per_d;
            dc_q     <= dc_d;
            ext_dc_q <= ext_dc_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            pwm_q    <= pwm_d;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;
    assign o_pwm     = pwm_q;
endmodule

// File: tb/tb_pwm_timer.sv
// tb_pwm_timer: directed bench for pwm_timer; expected read data and PWM
// phase lengths go through a scoreboard queue and are popped when observed.
module tb_pwm_timer;
    logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  adr = 4'd0;
    logic [15:0] wdat = 16'd0, rdat, dcin = 16'd0;
    logic        ack, ext = 1'b0, dcv = 1'b0, pwm;
    int          total = 0, bad = 0;
    int          sb[$];

    pwm_timer dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_data(wdat), .o_wb_ack(ack), .o_wb_data(rdat),
        .i_extclk(ext), .i_DC(dcin), .i_DC_valid(dcv), .o_pwm(pwm)
    );

    always #5 clk = ~clk;
    initial forever #40 ext = ~ext;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        do begin
            @(posedge clk); #1; n++;
        end while (ack !== 1'b1 && n < 8);
        chk("ack_latency", n, 1);
        if (!w) chk("read_data", rdat, sb.pop_front());
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", ack, 0);
    endtask

    task automatic rd(input logic [3:0] a, input int exp);
        sb.push_back(exp);
        wb(1'b0, a, 16'd0);
    endtask

    task automatic pwm_meas(input int hi, input int lo, input int np);
        int t = 0;
        for (int i = 0; i < np; i++) begin
            sb.push_back(hi);
            sb.push_back(lo);
        end
        while (pwm !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
        while (pwm !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        chk("pwm_sync_in_time", t < 3000, 1);
        for (int i = 0; i < np; i++) begin
            int h = 0, l = 0;
            while (pwm === 1'b1 && h < 3000) begin h++; @(negedge clk); end
            while (pwm === 1'b0 && l < 3000) begin l++; @(negedge clk); end
            chk("pwm_high_len", h, sb.pop_front());
            chk("pwm_low_len", l, sb.pop_front());
        end
    endtask

    task automatic const_chk(input string tag, input logic v, input int n);
        int e = 0;
        repeat (3) @(negedge clk);
        repeat (n) begin
            @(negedge clk);
            if (pwm !== v) e++;
        end
        chk(tag, e, 0);
    endtask

    initial begin
        int h;
        repeat (2) @(negedge clk);
        chk("reset_pwm", pwm, 0);
        chk("reset_ack", ack, 0);
        chk("reset_rdata", rdat, 0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) rd(4'(a), 0);
        wb(1'b1, 4'h5, 16'hFFFF);
        rd(4'h5, 0);

        wb(1'b1, 4'h2, 16'd100);
        wb(1'b1, 4'h3, 16'd40);
        wb(1'b1, 4'h1, 16'd4);
        rd(4'h2, 100);
        rd(4'h3, 40);
        rd(4'h1, 4);

        wb(1'b1, 4'h0, 16'h0016);
        pwm_meas(160, 240, 3);

        @(negedge clk); dcin = 16'd50; dcv = 1'b1;
        @(negedge clk); dcv = 1'b0; dcin = 16'd7;
        wb(1'b1, 4'h0, 16'h0056);
        pwm_meas(200, 200, 3);
        rd(4'h3, 40);

        wb(1'b1, 4'h0, 16'h0016);
        wb(1'b1, 4'h3, 16'd0);
        const_chk("dc0_const_low", 1'b0, 500);
        wb(1'b1, 4'h3, 16'd150);
        const_chk("dc_over_period_const_high", 1'b1, 500);
        wb(1'b1, 4'h2, 16'd0);
        const_chk("period0_const_low", 1'b0, 500);
        wb(1'b1, 4'h2, 16'd100);
        wb(1'b1, 4'h3, 16'd40);
        wb(1'b1, 4'h0, 16'h0096);
        repeat (20) @(negedge clk);
        wb(1'b1, 4'h0, 16'h0016);
        @(negedge clk);
        h = 0;
        while (pwm === 1'b1 && h < 3000) begin h++; @(negedge clk); end
        chk("counter_rst_full_high", h, 160);

        wb(1'b1, 4'h1, 16'd1);
        wb(1'b1, 4'h2, 16'd10);
        wb(1'b1, 4'h0, 16'h0014);
        pwm_meas(1, 9, 3);
        rd(4'h0, 16'h0034);
        wb(1'b1, 4'h1, 16'd100);
        wb(1'b1, 4'h0, 16'h0014);
        rd(4'h0, 16'h0014);
        repeat (1100) @(negedge clk);
        rd(4'h0, 16'h0034);

        wb(1'b1, 4'h1, 16'd1);
        wb(1'b1, 4'h0, 16'h0015);
        pwm_meas(1, 79, 2);

        @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h3; wdat = 16'd9;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_midxfer_ack", ack, 0);
        chk("reset_midxfer_pwm", pwm, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        rd(4'h3, 0);
        rd(4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
